ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter TIMER_100USEC_VALUE, default 1250, meaning wb_clk_i cycles in the 100 us clock-inhibit period.
REQ-002 SHALL have parameter TIMER_100USEC_BITS, default 11, meaning the inhibit counter width.
REQ-003 SHALL have parameter TIMEOUT_VALUE, default 25000, meaning the watchdog limit in wb_clk_i cycles (2 ms).
REQ-004 SHALL have parameter TIMEOUT_BITS, default 15, meaning the watchdog counter width.
REQ-005 wb_clk_i  in  1  single system clock; all logic on its rising edge.
REQ-006 wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 wb_adr_i  in  1  0 = TX data register, 1 = status register.
REQ-008 wb_dat_i  in  8  command byte to transmit.
REQ-009 wb_dat_o  out  8  read data: status {5'b0, err, ack_ok, busy} when wb_adr_i=1, else 8'h00.
REQ-010 wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone slave controls.
REQ-011 wb_ack_o  out  1  Wishbone acknowledge.
REQ-012 wb_tgc_o  out  1  one-cycle completion interrupt pulse.
REQ-013 ps2_clk_i, ps2_data_i  in  1 each  raw pad levels.
REQ-014 ps2_clk_oe_o, ps2_data_oe_o  out  1 each  1 = drive pad low; 0 = release the pad (high-Z). The top level owns the tristates.

Function
REQ-015 Pad inputs SHALL pass through a 2-flop synchronizer; a falling edge is the synced level going 1->0. Detection latency is 3 cycles from the pad.
REQ-016 wb_ack_o SHALL assert one cycle after wb_stb_i&wb_cyc_i and be low the following cycle. It is a single-cycle pulse per access; there are no wait states.
REQ-017 A write to adr 0 while idle SHALL latch the byte, set busy, clear ack_ok/err, and start the state machine.
REQ-018 A write to adr 0 while busy SHALL be acknowledged and ignored. A write to adr 1 SHALL be a no-op.
REQ-019 State IDLE: both oe=0; on accepted write -> INHIBIT.
REQ-020 State INHIBIT: clk_oe=1 for exactly TIMER_100USEC_VALUE cycles, then -> REQ.
REQ-021 State REQ: data_oe=1 (start bit) and clk_oe=0 in the same cycle, then -> DATA with bit index 0.
REQ-022 State DATA: on each falling edge, data_oe = ~byte[idx], LSB first. After bit 7, -> PARITY.
REQ-023 State PARITY: on the falling edge, drive odd parity, data_oe = ^byte (the 1-bit XOR reduction, so the line level is ~^byte). Then -> STOP.
REQ-024 State STOP: on the falling edge, release data (data_oe=0), then -> ACKW.
REQ-025 State ACKW: on the next falling edge, sample synced data. If 0, set ack_ok; if 1, set err. Then -> DONE.
REQ-026 State DONE: clear busy, pulse wb_tgc_o for one cycle, -> IDLE.
REQ-027 Pad clock edges seen in IDLE SHALL be ignored.
REQ-028 A watchdog counting from REQ until DONE SHALL force err=1, release both pads, pulse wb_tgc_o, and -> IDLE when it reaches TIMEOUT_VALUE.
REQ-029 A status read and a completion in the same cycle SHALL return the pre-update status.

Reset
REQ-030 While wb_rst_n_i=0, all of the following SHALL hold: state=IDLE, both oe=0, busy=ack_ok=err=0, wb_ack_o=0, wb_tgc_o=0, counters=0, synchronizers=1.
REQ-031 Reset asserted mid-frame SHALL release both pads asynchronously. After deassertion the block is idle and the aborted byte is discarded.

Configuration
REQ-032 With macro PS2_TX_TIMEOUT_EN defined, the watchdog of REQ-028 SHALL be present.
REQ-033 Without PS2_TX_TIMEOUT_EN, the watchdog logic SHALL be absent, err is set only by a missing ack bit, and the FSM waits indefinitely for device clocks.

Structure
REQ-034 Package ps2_pkg SHALL hold the following:
  - the FSM state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACKW, DONE);
  - the status bit-position constants;
  - the default timing constants.
REQ-035 One sub-module, ps2_sync, SHALL implement the 2-flop synchronizer plus falling-edge detect, instantiated once per pad.

Verification
REQ-036 Write 8'hED at adr 0; the device model clocks 11 falling edges and drives ack=0. Required response:
  - clk_oe high for 1250 cycles;
  - serial bits 1,0,1,1,0,1,1,1; parity line level 1 (6 ones -> odd parity bit 1); stop bit 1;
  - status reads 8'h02 and wb_tgc_o pulses once.
REQ-037 Write 8'h00; the device leaves data high at the ack slot. Required: parity line level 1, status reads 8'h04, wb_tgc_o pulses once.
REQ-038 Write 8'hFF, then write 8'h55 while busy. Required: only 8'hFF is transmitted, and both writes are acked in 1 cycle.
REQ-039 Write 8'hF4 and supply no device clocks. With PS2_TX_TIMEOUT_EN: status 8'h04 after 25000 cycles, pads released. Without it: busy stays at 8'h01.
REQ-040 Assert wb_rst_n_i=0 after 4 data bits of 8'hAA. Required: both oe=0 in the same cycle, status 8'h00 after release, no wb_tgc_o pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type, status bit positions and default timing for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACKW, DONE} state_t;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_ACK_OK = 1;
    localparam int STAT_ERR    = 2;

    localparam int DEF_TIMER_100USEC_VALUE = 1250;
    localparam int DEF_TIMER_100USEC_BITS  = 11;
    localparam int DEF_TIMEOUT_VALUE       = 25000;
    localparam int DEF_TIMEOUT_BITS        = 15;

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop pad synchronizer reset to the idle-high level, with registered falling-edge detect.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic s0;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0    <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            s0    <= pad;
            level <= s0;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: Wishbone-controlled PS/2 host-to-device command transmitter.
// Define PS2_TX_TIMEOUT_EN to include the frame watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int TIMER_100USEC_VALUE = DEF_TIMER_100USEC_VALUE,
    parameter int TIMER_100USEC_BITS  = DEF_TIMER_100USEC_BITS,
    parameter int TIMEOUT_VALUE       = DEF_TIMEOUT_VALUE,
    parameter int TIMEOUT_BITS        = DEF_TIMEOUT_BITS
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    input  logic       wb_cyc_i,
    output logic       wb_ack_o,
    output logic       wb_tgc_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    state_t                        state, state_n;
    logic [TIMER_100USEC_BITS-1:0] cnt, cnt_n;
    logic [2:0]                    idx, idx_n;
    logic [7:0]                    tx_byte, tx_byte_n;
    logic                          busy, busy_n, ack_ok, ack_ok_n, err, err_n;
    logic                          clk_oe_n, data_oe_n, tgc_n;
    logic                          clk_fall, data_lvl, clk_lvl, data_fall;
    logic                          access, wr;
    logic [7:0]                    status;
`ifdef PS2_TX_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0]       wd, wd_n;
`endif

    ps2_sync u_clk_sync  (.clk(wb_clk_i), .rst_n(wb_rst_n_i), .pad(ps2_clk_i),  .level(clk_lvl),  .fall(clk_fall));
    ps2_sync u_data_sync (.clk(wb_clk_i), .rst_n(wb_rst_n_i), .pad(ps2_data_i), .level(data_lvl), .fall(data_fall));

    assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr     = access & wb_we_i & ~wb_adr_i;

    always_comb begin
        status              = 8'h00;
        status[STAT_BUSY]   = busy;
        status[STAT_ACK_OK] = ack_ok;
        status[STAT_ERR]    = err;
    end

    // Read data is captured at the access edge, so a same-cycle completion shows the old status.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            wb_ack_o <= access;
            if (access)
                wb_dat_o <= wb_adr_i ? status : 8'h00;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            tx_byte       <= '0;
            busy          <= 1'b0;
            ack_ok        <= 1'b0;
            err           <= 1'b0;
            ps2_clk_oe_o  <= 1'b0;
            ps2_data_oe_o <= 1'b0;
            wb_tgc_o      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd            <= '0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            tx_byte       <= tx_byte_n;
            busy          <= busy_n;
            ack_ok        <= ack_ok_n;
            err           <= err_n;
            ps2_clk_oe_o  <= clk_oe_n;
            ps2_data_oe_o <= data_oe_n;
            wb_tgc_o      <= tgc_n;
`ifdef PS2_TX_TIMEOUT_EN
            wd            <= wd_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        tx_byte_n = tx_byte;
        busy_n    = busy;
        ack_ok_n  = ack_ok;
        err_n     = err;
        clk_oe_n  = ps2_clk_oe_o;
        data_oe_n = ps2_data_oe_o;
        tgc_n     = 1'b0;
        case (state)
            IDLE: if (wr) begin
                tx_byte_n = wb_dat_i;
                busy_n    = 1'b1;
                ack_ok_n  = 1'b0;
                err_n     = 1'b0;
                cnt_n     = '0;
                clk_oe_n  = 1'b1;
                state_n   = INHIBIT;
            end
            INHIBIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == TIMER_100USEC_BITS'(TIMER_100USEC_VALUE - 1)) begin
                    cnt_n     = '0;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    state_n   = REQ;
                end
            end
            REQ: begin
                idx_n   = '0;
                state_n = DATA;
            end
            DATA: if (clk_fall) begin
                data_oe_n = ~tx_byte[idx];
                idx_n     = idx + 3'd1;
                state_n   = (idx == 3'd7) ? PARITY : DATA;
            end
            PARITY: if (clk_fall) begin
                data_oe_n = ^tx_byte;
                state_n   = STOP;
            end
            STOP: if (clk_fall) begin
                data_oe_n = 1'b0;
                state_n   = ACKW;
            end
            ACKW: if (clk_fall) begin
                ack_ok_n = ~data_lvl;
                err_n    = data_lvl;
                state_n  = DONE;
            end
            DONE: begin
                busy_n  = 1'b0;
                tgc_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        wd_n = (state inside {REQ, DATA, PARITY, STOP, ACKW}) ? wd + 1'b1 : '0;
        if ((state inside {REQ, DATA, PARITY, STOP, ACKW}) && wd == TIMEOUT_BITS'(TIMEOUT_VALUE - 1)) begin
            wd_n      = '0;
            err_n     = 1'b1;
            ack_ok_n  = 1'b0;
            busy_n    = 1'b0;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            tgc_n     = 1'b1;
            state_n   = IDLE;
        end
`endif
    end

endmodule
